// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_if: LSU, instruction-fetch and memory-port bundle              |
// |   for the shared memory-port arbiter.                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  lsu_req_i;
    logic                  lsu_we_i;
    logic [ADDR_W-1:0]     lsu_addr_i;
    logic [DATA_W-1:0]     lsu_wdata_i;
    logic [DATA_W/8-1:0]   lsu_wstrb_i;
    logic                  lsu_ack_o;
    logic [DATA_W-1:0]     lsu_rdata_o;
    logic                  lsu_err_o;

    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic                  if_ack_o;
    logic [DATA_W-1:0]     if_rdata_o;
    logic                  if_err_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_wstrb_o;
    logic                  mem_ack_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    logic                  hold_flag_o;

    // Arbiter side
    modport slave (
        input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wstrb_i,
        output lsu_ack_o, lsu_rdata_o, lsu_err_o,
        input  if_req_i, if_addr_i,
        output if_ack_o, if_rdata_o, if_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_ack_i, mem_rdata_i,
        output hold_flag_o
    );

    // Requester / memory side
    modport master (
        output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wstrb_i,
        input  lsu_ack_o, lsu_rdata_o, lsu_err_o,
        output if_req_i, if_addr_i,
        input  if_ack_o, if_rdata_o, if_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_ack_i, mem_rdata_i,
        input  hold_flag_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: LSU-priority arbiter for the shared memory port with an       |
// |   IF anti-starvation guard, bus timeout and pipeline stall request.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SC_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int WC_W   = $clog2(TIMEOUT + 1);

    localparam logic [SC_W-1:0] c_STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [WC_W-1:0] c_WAIT_LIM   = WC_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GNT_LSU = 2'd1;
    localparam logic [1:0] c_GNT_IF  = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [SC_W-1:0]   starve_q,    starve_d;
    logic [WC_W-1:0]   wait_q,      wait_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              lsu_ack_q,   lsu_ack_d;
    logic              lsu_err_q,   lsu_err_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              if_err_q,    if_err_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;

    logic starve_hit;
    logic lsu_wins;
    logic done_now;
    logic [DATA_W-1:0] resp_data;

    // IF is forced through once it has lost STARVE_MAX arbitrations in a row
    assign starve_hit = bus.if_req_i && (starve_q == c_STARVE_LIM);
    assign lsu_wins   = bus.lsu_req_i && !starve_hit;
    // A same-cycle ack beats the timeout
    assign done_now   = bus.mem_ack_i || (wait_q == c_WAIT_LIM);
    assign resp_data  = bus.mem_ack_i ? bus.mem_rdata_i : '0;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        lsu_ack_d   = lsu_ack_q;
        lsu_err_d   = lsu_err_q;
        lsu_rdata_d = lsu_rdata_q;
        if_ack_d    = if_ack_q;
        if_err_d    = if_err_q;
        if_rdata_d  = if_rdata_q;

        case (state_q)
            c_IDLE: begin
                if (bus.lsu_req_i || bus.if_req_i) begin
                    mem_req_d = 1'b1;
                    wait_d    = '0;
                    if (lsu_wins) begin
                        state_d     = c_GNT_LSU;
                        mem_we_d    = bus.lsu_we_i;
                        mem_addr_d  = bus.lsu_addr_i;
                        mem_wdata_d = bus.lsu_wdata_i;
                        mem_wstrb_d = bus.lsu_wstrb_i;
                        if (bus.if_req_i && (starve_q != c_STARVE_LIM)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        state_d     = c_GNT_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr_i;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                        starve_d    = '0;
                    end
                end
            end
            c_GNT_LSU, c_GNT_IF: begin
                if (done_now) begin
                    state_d   = c_RESP;
                    mem_req_d = 1'b0;
                    if (state_q == c_GNT_LSU) begin
                        lsu_ack_d   = 1'b1;
                        lsu_err_d   = !bus.mem_ack_i;
                        lsu_rdata_d = resp_data;
                    end else begin
                        if_ack_d    = 1'b1;
                        if_err_d    = !bus.mem_ack_i;
                        if_rdata_d  = resp_data;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            c_RESP: begin
                state_d   = c_IDLE;
                lsu_ack_d = 1'b0;
                lsu_err_d = 1'b0;
                if_ack_d  = 1'b0;
                if_err_d  = 1'b0;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            lsu_ack_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
            lsu_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            lsu_ack_q   <= lsu_ack_d;
            lsu_err_q   <= lsu_err_d;
            lsu_rdata_q <= lsu_rdata_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_wstrb_o = mem_wstrb_q;
    assign bus.lsu_ack_o   = lsu_ack_q;
    assign bus.lsu_err_o   = lsu_err_q;
    assign bus.lsu_rdata_o = lsu_rdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.if_err_o    = if_err_q;
    assign bus.if_rdata_o  = if_rdata_q;

    // Stall until the requester sees its own completion pulse
    assign bus.hold_flag_o = (bus.if_req_i & ~if_ack_q) | (bus.lsu_req_i & ~lsu_ack_q);

endmodule
`default_nettype wire
